// File: rtl/bsg_axi_mem_rw_scheduler.sv
// Single-port word array scheduler for one AXI write-burst and one AXI read-burst stream.
// Optional range checking: define BSG_AXI_MEM_SCHED_RANGE_CHECK_EN.
module bsg_axi_mem_rw_scheduler #(
    parameter int axi_addr_width_p = 64,
    parameter int axi_data_width_p = 64,
    parameter int axi_len_width_p  = 8,
    parameter int mem_els_p        = 64,
    localparam int strb_width_lp   = axi_data_width_p >> 3,
    localparam int lg_strb_lp      = (strb_width_lp > 1) ? $clog2(strb_width_lp) : 0,
    localparam int lg_mem_els_lp   = (mem_els_p > 1) ? $clog2(mem_els_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        aw_v_i,
    output logic                        aw_ready_o,
    input  logic [axi_addr_width_p-1:0] aw_addr_i,
    input  logic [axi_len_width_p-1:0]  aw_len_i,
    input  logic                        w_v_i,
    output logic                        w_ready_o,
    input  logic [axi_data_width_p-1:0] w_data_i,
    input  logic [strb_width_lp-1:0]    w_strb_i,
    input  logic                        w_last_i,
    output logic                        b_v_o,
    input  logic                        b_ready_i,
    output logic [1:0]                  b_resp_o,
    input  logic                        ar_v_i,
    output logic                        ar_ready_o,
    input  logic [axi_addr_width_p-1:0] ar_addr_i,
    input  logic [axi_len_width_p-1:0]  ar_len_i,
    output logic                        r_v_o,
    input  logic                        r_ready_i,
    output logic [axi_data_width_p-1:0] r_data_o,
    output logic [1:0]                  r_resp_o,
    output logic                        r_last_o,
    output logic                        mem_v_o,
    output logic                        mem_w_o,
    output logic [lg_mem_els_lp-1:0]    mem_idx_o,
    output logic [axi_data_width_p-1:0] mem_data_o,
    output logic [strb_width_lp-1:0]    mem_mask_o,
    input  logic [axi_data_width_p-1:0] mem_data_i
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WRESP, S_READ} state_e;

    state_e                        state_q, state_d;
    logic                          rr_q, rr_d;
    logic [lg_mem_els_lp-1:0]      idx_q, idx_d;
    logic [axi_len_width_p-1:0]    wcnt_q, wcnt_d;
    logic                          err_q, err_d;
    logic [axi_len_width_p:0]      issue_rem_q, issue_rem_d;
    logic [axi_len_width_p-1:0]    pop_rem_q, pop_rem_d;
    logic                          inflight_q;
    logic                          wr_ptr_q, rd_ptr_q;
    logic [1:0]                    cnt_q, cnt_d;
    logic [axi_data_width_p-1:0]   fifo_q [2];

    logic                          grant_w, grant_r;
    logic [axi_addr_width_p-1:0]   cmd_word;
    logic [axi_len_width_p-1:0]    cmd_len;
    logic [lg_mem_els_lp-1:0]      cmd_idx, idx_inc;
    logic                          cmd_err;
    logic                          fifo_room, issue, push, pop, mem_v;
    logic                          unused_w_last;

    assign unused_w_last = w_last_i;

    // rr_q set means the read side wins the next tie
    assign grant_w  = aw_v_i && (!ar_v_i || !rr_q);
    assign grant_r  = ar_v_i && (!aw_v_i || rr_q);
    assign cmd_word = grant_w ? (aw_addr_i >> lg_strb_lp) : (ar_addr_i >> lg_strb_lp);
    assign cmd_len  = grant_w ? aw_len_i : ar_len_i;
    assign cmd_idx  = lg_mem_els_lp'(cmd_word % axi_addr_width_p'(mem_els_p));
    assign idx_inc  = (idx_q == lg_mem_els_lp'(mem_els_p - 1)) ? '0 : idx_q + 1'b1;

`ifdef BSG_AXI_MEM_SCHED_RANGE_CHECK_EN
    assign cmd_err = ({1'b0, cmd_word} + {{(axi_addr_width_p - axi_len_width_p + 1){1'b0}}, cmd_len})
                     >= (axi_addr_width_p + 1)'(mem_els_p);
`else
    assign cmd_err = 1'b0;
`endif

    // FIFO occupancy plus the one-cycle array read in flight never exceeds two
    assign fifo_room = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && !inflight_q);
    assign issue     = (state_q == S_READ) && (issue_rem_q != '0) && fifo_room;
    assign push      = inflight_q;
    assign r_v_o     = (cnt_q != 2'd0);
    assign pop       = r_v_o && r_ready_i;
    assign mem_v     = !err_q && (((state_q == S_WRITE) && w_v_i) || issue);

    assign r_data_o  = r_v_o ? fifo_q[rd_ptr_q] : '0;
    assign r_last_o  = r_v_o && (pop_rem_q == '0);
    assign r_resp_o  = (r_v_o && err_q) ? 2'b10 : 2'b00;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        err_d       = err_q;
        issue_rem_d = issue_rem_q;
        pop_rem_d   = pop_rem_q;
        cnt_d       = cnt_q + 2'(push) - 2'(pop);
        aw_ready_o  = 1'b0;
        ar_ready_o  = 1'b0;
        w_ready_o   = 1'b0;
        b_v_o       = 1'b0;
        b_resp_o    = 2'b00;
        mem_v_o     = mem_v;
        mem_w_o     = mem_v && (state_q == S_WRITE);
        mem_idx_o   = mem_v ? idx_q : '0;
        mem_data_o  = (mem_v && (state_q == S_WRITE)) ? w_data_i : '0;
        mem_mask_o  = (mem_v && (state_q == S_WRITE)) ? w_strb_i : '0;

        case (state_q)
            S_IDLE: begin
                // ready gated by reset so every output is low while reset is held
                aw_ready_o = reset_n_i && grant_w;
                ar_ready_o = reset_n_i && grant_r;
                if (grant_w) begin
                    state_d = S_WRITE;
                    idx_d   = cmd_idx;
                    wcnt_d  = cmd_len;
                    err_d   = cmd_err;
                    if (ar_v_i) rr_d = 1'b1;
                end else if (grant_r) begin
                    state_d     = S_READ;
                    idx_d       = cmd_idx;
                    issue_rem_d = {1'b0, cmd_len} + 1'b1;
                    pop_rem_d   = cmd_len;
                    err_d       = cmd_err;
                    if (aw_v_i) rr_d = 1'b0;
                end
            end
            S_WRITE: begin
                w_ready_o = 1'b1;
                if (w_v_i) begin
                    idx_d = idx_inc;
                    if (wcnt_q == '0) state_d = S_WRESP;
                    else              wcnt_d  = wcnt_q - 1'b1;
                end
            end
            S_WRESP: begin
                b_v_o    = 1'b1;
                b_resp_o = err_q ? 2'b10 : 2'b00;
                if (b_ready_i) state_d = S_IDLE;
            end
            S_READ: begin
                if (issue) begin
                    issue_rem_d = issue_rem_q - 1'b1;
                    idx_d       = idx_inc;
                end
                if (pop) begin
                    if (pop_rem_q == '0) state_d   = S_IDLE;
                    else                 pop_rem_d = pop_rem_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            rr_q        <= 1'b0;
            idx_q       <= '0;
            wcnt_q      <= '0;
            err_q       <= 1'b0;
            issue_rem_q <= '0;
            pop_rem_q   <= '0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
            issue_rem_q <= issue_rem_d;
            pop_rem_q   <= pop_rem_d;
            inflight_q  <= issue;
            wr_ptr_q    <= wr_ptr_q ^ push;
            rd_ptr_q    <= rd_ptr_q ^ pop;
            cnt_q       <= cnt_d;
        end
    end

    // Out-of-range bursts still produce beats, carrying zero data
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= err_q ? '0 : mem_data_i;
    end

endmodule

// File: tb/tb_bsg_axi_mem_rw_scheduler.sv
// Directed bench for bsg_axi_mem_rw_scheduler: table of bursts plus arbitration, stall and reset sequences.
module tb_bsg_axi_mem_rw_scheduler;

`ifdef BSG_AXI_MEM_SCHED_RANGE_CHECK_EN
    localparam bit rc = 1'b1;
`else
    localparam bit rc = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        aw_v_i = 0, w_v_i = 0, w_last_i = 0, b_ready_i = 0, ar_v_i = 0, r_ready_i = 0;
    logic [63:0] aw_addr_i = 0, ar_addr_i = 0, w_data_i = 0, mem_data_i = 0;
    logic [7:0]  aw_len_i = 0, ar_len_i = 0, w_strb_i = 0;
    logic        aw_ready_o, w_ready_o, b_v_o, ar_ready_o, r_v_o, r_last_o, mem_v_o, mem_w_o;
    logic [1:0]  b_resp_o, r_resp_o;
    logic [63:0] r_data_o, mem_data_o;
    logic [5:0]  mem_idx_o;
    logic [7:0]  mem_mask_o;

    int checks = 0;
    int failures = 0;

    logic [63:0] tb_mem [64];
    logic [5:0]  rd_log [$];

    bsg_axi_mem_rw_scheduler dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .aw_v_i(aw_v_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i),
        .w_v_i(w_v_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_last_i(w_last_i),
        .b_v_o(b_v_o), .b_ready_i(b_ready_i), .b_resp_o(b_resp_o),
        .ar_v_i(ar_v_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
        .r_v_o(r_v_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_idx_o(mem_idx_o), .mem_data_o(mem_data_o),
        .mem_mask_o(mem_mask_o), .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    // Storage array behind the scheduler: one-cycle read latency, byte-masked writes
    always @(posedge clk) begin
        if (mem_v_o) begin
            if (mem_w_o) begin
                for (int b = 0; b < 8; b++)
                    if (mem_mask_o[b]) tb_mem[mem_idx_o][8*b +: 8] <= mem_data_o[8*b +: 8];
            end else begin
                mem_data_i <= tb_mem[mem_idx_o];
            end
        end
    end

    always @(posedge clk) begin
        if (reset_n_i && mem_v_o && !mem_w_o) rd_log.push_back(mem_idx_o);
    end

    typedef struct {
        logic             wr;
        logic [63:0]      addr;
        logic [7:0]       len;
        logic [7:0]       strb;
        logic [7:0][63:0] data;
        logic [7:0][5:0]  idx;
        logic             mv;
        logic [1:0]       resp;
    } vec_t;

    vec_t vecs [9];
    vec_t arb_w, arb_r, arb_w2, stall_r, rst_w, rst_r;

    function automatic vec_t mk(input logic wr, input logic [63:0] addr, input logic [7:0] len,
                                input logic [7:0] strb, input logic [63:0] d0, d1, d2, d3,
                                input logic [5:0] i0, i1, i2, i3, input logic mv, input logic [1:0] resp);
        vec_t v;
        v.wr = wr; v.addr = addr; v.len = len; v.strb = strb; v.mv = mv; v.resp = resp;
        v.data = '0; v.idx = '0;
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
        v.idx[0] = i0; v.idx[1] = i1; v.idx[2] = i2; v.idx[3] = i3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Entered just after a falling edge with the scheduler idle; returns after the accepting edge
    task automatic cmd(input vec_t v);
        int n;
        n = 0;
        if (v.wr) begin
            aw_v_i = 1; aw_addr_i = v.addr; aw_len_i = v.len;
        end else begin
            ar_v_i = 1; ar_addr_i = v.addr; ar_len_i = v.len;
            rd_log.delete();
        end
        #1;
        while (!(v.wr ? aw_ready_o : ar_ready_o) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("cmd_ready", 64'(v.wr ? aw_ready_o : ar_ready_o), 64'd1);
        @(negedge clk);
        aw_v_i = 0; ar_v_i = 0;
    endtask

    task automatic data_write(input vec_t v);
        for (int b = 0; b <= int'(v.len); b++) begin
            w_v_i = 1; w_data_i = v.data[b]; w_strb_i = v.strb; w_last_i = (b == int'(v.len));
            #1;
            chk("w_ready", 64'(w_ready_o), 64'd1);
            chk("wr_mem_v", 64'(mem_v_o), 64'(v.mv));
            if (v.mv) begin
                chk("wr_mem_w", 64'(mem_w_o), 64'd1);
                chk("wr_mem_idx", 64'(mem_idx_o), 64'(v.idx[b]));
                chk("wr_mem_data", mem_data_o, v.data[b]);
                chk("wr_mem_mask", 64'(mem_mask_o), 64'(v.strb));
            end
            @(negedge clk);
        end
        w_v_i = 0; w_last_i = 0; b_ready_i = 1;
        #1;
        chk("b_v", 64'(b_v_o), 64'd1);
        chk("b_resp", 64'(b_resp_o), 64'(v.resp));
        @(negedge clk);
        b_ready_i = 0;
        #1;
        chk("b_done", 64'(b_v_o), 64'd0);
        $display("write addr=%h len=%0d b_resp=%0d", v.addr, v.len, v.resp);
    endtask

    task automatic data_read(input vec_t v);
        int beat, cyc, exp_n;
        beat = 0; cyc = 0;
        r_ready_i = 1;
        while (beat <= int'(v.len) && cyc < 100) begin
            #1;
            if (r_v_o) begin
                chk("r_data", r_data_o, v.data[beat]);
                chk("r_last", 64'(r_last_o), 64'(beat == int'(v.len)));
                chk("r_resp", 64'(r_resp_o), 64'(v.resp));
                beat++;
            end
            @(negedge clk);
            cyc++;
        end
        r_ready_i = 0;
        chk("r_beats", 64'(beat), 64'(int'(v.len) + 1));
        #1;
        chk("r_done", 64'(r_v_o), 64'd0);
        exp_n = v.mv ? int'(v.len) + 1 : 0;
        chk("rd_issues", 64'(rd_log.size()), 64'(exp_n));
        for (int i = 0; i < rd_log.size() && i < 8; i++)
            chk("rd_mem_idx", 64'(rd_log[i]), 64'(v.idx[i]));
        $display("read addr=%h len=%0d beats=%0d", v.addr, v.len, beat);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tb_mem[i] = 64'd0;

        vecs[0] = mk(1, 64'h10, 8'd3, 8'hFF, 64'd1, 64'd2, 64'd3, 64'd4, 6'd2, 6'd3, 6'd4, 6'd5, 1'b1, 2'b00);
        vecs[1] = mk(0, 64'h10, 8'd3, 8'hFF, 64'd1, 64'd2, 64'd3, 64'd4, 6'd2, 6'd3, 6'd4, 6'd5, 1'b1, 2'b00);
        vecs[2] = mk(1, 64'h1F0, 8'd3, 8'hFF, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 6'd62, 6'd63, 6'd0, 6'd1,
                     !rc, rc ? 2'b10 : 2'b00);
        vecs[3] = mk(0, 64'h1F0, 8'd3, 8'hFF, rc ? 64'd0 : 64'hA0, rc ? 64'd0 : 64'hA1, rc ? 64'd0 : 64'hA2,
                     rc ? 64'd0 : 64'hA3, 6'd62, 6'd63, 6'd0, 6'd1, !rc, rc ? 2'b10 : 2'b00);
        vecs[4] = mk(1, 64'h18, 8'd0, 8'h0F, 64'hDEADBEEF_CAFEF00D, 0, 0, 0, 6'd3, 0, 0, 0, 1'b1, 2'b00);
        vecs[5] = mk(0, 64'h18, 8'd0, 8'hFF, 64'h00000000_CAFEF00D, 0, 0, 0, 6'd3, 0, 0, 0, 1'b1, 2'b00);
        vecs[6] = mk(1, 64'h200, 8'd0, 8'hFF, 64'h99, 0, 0, 0, 6'd0, 0, 0, 0, !rc, rc ? 2'b10 : 2'b00);
        vecs[7] = mk(0, 64'h200, 8'd0, 8'hFF, rc ? 64'd0 : 64'h99, 0, 0, 0, 6'd0, 0, 0, 0,
                     !rc, rc ? 2'b10 : 2'b00);
        vecs[8] = mk(1, 64'h40, 8'd7, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 2'b00);
        for (int i = 0; i < 8; i++) begin
            vecs[8].data[i] = 64'h100 + 64'(i);
            vecs[8].idx[i]  = 6'd8 + 6'(i);
        end
        stall_r = vecs[8];
        stall_r.wr = 0;

        arb_w  = mk(1, 64'h8, 8'd0, 8'hFF, 64'h55, 0, 0, 0, 6'd1, 0, 0, 0, 1'b1, 2'b00);
        arb_r  = mk(0, 64'h8, 8'd0, 8'hFF, 64'h55, 0, 0, 0, 6'd1, 0, 0, 0, 1'b1, 2'b00);
        arb_w2 = mk(1, 64'h8, 8'd0, 8'hFF, 64'h66, 0, 0, 0, 6'd1, 0, 0, 0, 1'b1, 2'b00);
        rst_w  = mk(1, 64'h0, 8'd3, 8'hFF, 64'h77, 64'h78, 64'h79, 64'h7A, 6'd0, 6'd1, 6'd2, 6'd3, 1'b1, 2'b00);
        rst_r  = mk(0, 64'h0, 8'd0, 8'hFF, 64'h77, 0, 0, 0, 6'd0, 0, 0, 0, 1'b1, 2'b00);

        // Reset with requests pending: every output must stay low
        aw_v_i = 1; ar_v_i = 1; w_v_i = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctl", 64'({aw_ready_o, w_ready_o, b_v_o, b_resp_o, ar_ready_o, r_v_o, r_resp_o, r_last_o,
                              mem_v_o, mem_w_o, mem_idx_o, mem_mask_o}), 64'd0);
        chk("reset_r_data", r_data_o, 64'd0);
        @(negedge clk);
        aw_v_i = 0; ar_v_i = 0; w_v_i = 0;
        reset_n_i = 1;
        @(negedge clk);

        // Round-robin: write first out of reset, then read, then write again
        aw_v_i = 1; aw_addr_i = 64'h8; aw_len_i = 0; ar_v_i = 1; ar_addr_i = 64'h8; ar_len_i = 0;
        rd_log.delete();
        #1;
        chk("arb1_aw_ready", 64'(aw_ready_o), 64'd1);
        chk("arb1_ar_ready", 64'(ar_ready_o), 64'd0);
        @(negedge clk);
        aw_v_i = 0; ar_v_i = 0;
        data_write(arb_w);
        aw_v_i = 1; ar_v_i = 1;
        #1;
        chk("arb2_aw_ready", 64'(aw_ready_o), 64'd0);
        chk("arb2_ar_ready", 64'(ar_ready_o), 64'd1);
        @(negedge clk);
        aw_v_i = 0; ar_v_i = 0;
        data_read(arb_r);
        aw_v_i = 1; ar_v_i = 1;
        #1;
        chk("arb3_aw_ready", 64'(aw_ready_o), 64'd1);
        chk("arb3_ar_ready", 64'(ar_ready_o), 64'd0);
        @(negedge clk);
        aw_v_i = 0; ar_v_i = 0;
        data_write(arb_w2);

        for (int i = 0; i < 9; i++) begin
            cmd(vecs[i]);
            if (vecs[i].wr) data_write(vecs[i]);
            else            data_read(vecs[i]);
        end

        // Back-pressured read: only two array reads may be outstanding
        cmd(stall_r);
        repeat (10) @(negedge clk);
        #1;
        chk("stall_issued", 64'(rd_log.size()), 64'd2);
        chk("stall_mem_v", 64'(mem_v_o), 64'd0);
        chk("stall_r_v", 64'(r_v_o), 64'd1);
        chk("stall_r_data", r_data_o, 64'h100);
        chk("stall_r_last", 64'(r_last_o), 64'd0);
        @(negedge clk);
        data_read(stall_r);

        // Asynchronous reset in the middle of a write burst
        cmd(rst_w);
        for (int b = 0; b < 2; b++) begin
            w_v_i = 1; w_data_i = rst_w.data[b]; w_strb_i = 8'hFF;
            @(negedge clk);
        end
        w_data_i = rst_w.data[2]; aw_v_i = 1; ar_v_i = 1;
        reset_n_i = 0;
        #1;
        chk("midrst_ctl", 64'({aw_ready_o, w_ready_o, b_v_o, b_resp_o, ar_ready_o, r_v_o, r_resp_o, r_last_o,
                               mem_v_o, mem_w_o, mem_idx_o, mem_mask_o}), 64'd0);
        chk("midrst_mem_data", mem_data_o, 64'd0);
        chk("midrst_r_data", r_data_o, 64'd0);
        $display("reset asserted mid-write");
        @(negedge clk);
        @(negedge clk);
        w_v_i = 0; aw_v_i = 0; ar_v_i = 0;
        reset_n_i = 1;
        @(negedge clk);
        cmd(rst_r);
        data_read(rst_r);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
